fft_frame_loader: RTL and testbench

- Upstream neighbour of the 8-point `fft` core.
- Accepts a serial stream of complex Q8.8 samples over a valid/ready handshake and packs them into one 8-point frame.
- Drives the fft's `write`/`start` controls, then holds off new input until the fft reports `ready`.
- Turns a streaming ADC/DMA source into the parallel `in0..in7` frame the fft consumes.

---
 rtl/fft_pkg.sv | 8 +
 rtl/fft_frame_buf.sv | 31 +++
 rtl/fft_frame_loader.sv | 100 ++++++++++
 tb/tb_fft_frame_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, loader FSM encoding and Q8.8 sample type for the fft core family
package fft_pkg;
    localparam int DATA_W = 16;
    localparam int N_PTS  = 8;
    localparam int IDX_W  = 3;
    typedef enum logic [1:0] {FILL, PAD, LOAD, RUN} state_t;
    typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf: N_PTS complex-sample register file with indexed write, clear-from-index and packed read-out
//   CLK, RST_N          clock, async active-low reset
//   wr_en/wr_idx        write wr_real/wr_imag into slot wr_idx
//   clr_en/clr_idx      zero every slot at or above clr_idx
//   frame_real/imag     packed slots, slot k at [k*DATA_W +: DATA_W]
module fft_frame_buf import fft_pkg::*; (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic signed [DATA_W-1:0]  wr_real,
    input  logic signed [DATA_W-1:0]  wr_imag,
    input  logic                      clr_en,
    input  logic [IDX_W-1:0]          clr_idx,
    output logic [N_PTS*DATA_W-1:0]   frame_real,
    output logic [N_PTS*DATA_W-1:0]   frame_imag
);
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            frame_real <= '0;
            frame_imag <= '0;
        end else
            for (int k = 0; k < N_PTS; k++)
                if (wr_en && wr_idx == IDX_W'(k)) begin
                    frame_real[k*DATA_W +: DATA_W] <= wr_real;
                    frame_imag[k*DATA_W +: DATA_W] <= wr_imag;
                end else if (clr_en && IDX_W'(k) >= clr_idx) begin
                    frame_real[k*DATA_W +: DATA_W] <= '0;
                    frame_imag[k*DATA_W +: DATA_W] <= '0;
                end
endmodule

// File: rtl/fft_frame_loader.sv
// fft_frame_loader: packs a valid/ready stream of complex samples into an 8-point frame and launches the fft
//   CLK, RST_N              clock, async active-low reset
//   s_valid/s_ready         input sample handshake, s_real/s_imag sample data
//   flush                   zero-pad and launch a partial frame
//   frame_real/frame_imag   packed frame to fft inK_real/inK_imag
//   fft_write/fft_start     fft controls, fft_ready its completion flag
//   busy                    frame handed to fft, result pending
//   frames_done             completed-frame count, wraps
module fft_frame_loader import fft_pkg::*; #(
    parameter int CNT_W = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic signed [DATA_W-1:0]  s_real,
    input  logic signed [DATA_W-1:0]  s_imag,
    input  logic                      flush,
    output logic [N_PTS*DATA_W-1:0]   frame_real,
    output logic [N_PTS*DATA_W-1:0]   frame_imag,
    output logic                      fft_write,
    output logic                      fft_start,
    input  logic                      fft_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          frames_done
);
    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             ready_q;
    logic             accept;
    logic             last;

    // s_ready is high only in FILL, so it doubles as the state qualifier
    assign accept = s_valid && s_ready;
    assign last   = idx == IDX_W'(N_PTS-1);

    fft_frame_buf u_buf (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_en      (accept),
        .wr_idx     (idx),
        .wr_real    (s_real),
        .wr_imag    (s_imag),
        .clr_en     (state == PAD),
        .clr_idx    (idx),
        .frame_real (frame_real),
        .frame_imag (frame_imag)
    );

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state       <= FILL;
            idx         <= '0;
            s_ready     <= 1'b1;
            fft_write   <= 1'b0;
            fft_start   <= 1'b0;
            busy        <= 1'b0;
            frames_done <= '0;
            ready_q     <= 1'b0;
        end else begin
            ready_q <= fft_ready;
            case (state)
                FILL:
                    if (accept && last) begin
                        state     <= LOAD;
                        idx       <= '0;
                        s_ready   <= 1'b0;
                        fft_write <= 1'b1;
                    end else if (accept || (flush && idx != '0)) begin
                        // padding in PAD starts at the post-accept index
                        idx <= accept ? idx + 1'b1 : idx;
                        if (flush) begin
                            state   <= PAD;
                            s_ready <= 1'b0;
                        end
                    end
                PAD: begin
                    state     <= LOAD;
                    idx       <= '0;
                    fft_write <= 1'b1;
                end
                LOAD: begin
                    state     <= RUN;
                    fft_write <= 1'b0;
                    fft_start <= 1'b1;
                    busy      <= 1'b1;
                end
                RUN:
                    // a level-high fft_ready left from the previous frame is not an edge
                    if (fft_ready && !ready_q) begin
                        state       <= FILL;
                        fft_start   <= 1'b0;
                        busy        <= 1'b0;
                        s_ready     <= 1'b1;
                        frames_done <= frames_done + 1'b1;
                    end
                default: state <= FILL;
            endcase
        end
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: directed self-checking bench for fft_frame_loader
module tb_fft_frame_loader;
    logic         CLK, RST_N;
    logic         s_valid, s_ready, flush;
    logic [15:0]  s_real, s_imag;
    logic [127:0] frame_real, frame_imag;
    logic         fft_write, fft_start, fft_ready, busy;
    logic [7:0]   frames_done;
    logic [127:0] exp_re, exp_im;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cnt;

    fft_frame_loader dut (
        .CLK(CLK), .RST_N(RST_N), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .flush(flush),
        .frame_real(frame_real), .frame_imag(frame_imag),
        .fft_write(fft_write), .fft_start(fft_start), .fft_ready(fft_ready),
        .busy(busy), .frames_done(frames_done)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] re, input logic [15:0] im, input logic fl);
        @(negedge CLK);
        check("s_ready_fill", {127'd0, s_ready}, 128'd1);
        s_valid = 1; s_real = re; s_imag = im; flush = fl;
    endtask

    task automatic idle;
        @(negedge CLK);
        s_valid = 0; flush = 0;
    endtask

    initial begin
        RST_N = 0; s_valid = 0; flush = 0; s_real = 0; s_imag = 0; fft_ready = 0;
        repeat (2) @(negedge CLK);
        check("rst_s_ready", {127'd0, s_ready}, 128'd1);
        check("rst_write", {127'd0, fft_write}, 128'd0);
        check("rst_start", {127'd0, fft_start}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_frames", {120'd0, frames_done}, 128'd0);
        check("rst_frame", frame_real | frame_imag, 128'd0);
        RST_N = 1;

        // ramp frame
        exp_re = '0; exp_im = '0;
        for (int k = 0; k < 8; k++) begin
            push(16'(k * 256), 16'h0000, 0);
            exp_re[k*16 +: 16] = 16'(k * 256);
        end
        idle;
        check("ramp_write_t1", {127'd0, fft_write}, 128'd1);
        check("ramp_start_t1", {127'd0, fft_start}, 128'd0);
        check("ramp_sready_t1", {127'd0, s_ready}, 128'd0);
        @(negedge CLK);
        check("ramp_write_t2", {127'd0, fft_write}, 128'd0);
        check("ramp_start_t2", {127'd0, fft_start}, 128'd1);
        check("ramp_busy", {127'd0, busy}, 128'd1);
        check("ramp_real", frame_real, exp_re);
        check("ramp_imag", frame_imag, exp_im);
        repeat (20) @(negedge CLK);
        check("ramp_hold", {127'd0, fft_start}, 128'd1);
        fft_ready = 1;
        @(negedge CLK);
        check("ramp_frames", {120'd0, frames_done}, 128'd1);
        check("ramp_sready", {127'd0, s_ready}, 128'd1);
        check("ramp_busy_off", {127'd0, busy}, 128'd0);

        // back-pressure: s_valid held for 60 cycles, fft_ready low
        fft_ready = 0; cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            s_valid = 1; s_real = 16'h1000 + 16'(i); s_imag = 16'h2000 + 16'(i);
            if (s_ready) begin
                if (cnt < 8) begin
                    exp_re[cnt*16 +: 16] = s_real;
                    exp_im[cnt*16 +: 16] = s_imag;
                end
                cnt++;
            end
        end
        idle;
        check("bp_count", 128'(cnt), 128'd8);
        check("bp_sready", {127'd0, s_ready}, 128'd0);
        check("bp_start", {127'd0, fft_start}, 128'd1);
        check("bp_real", frame_real, exp_re);
        check("bp_imag", frame_imag, exp_im);
        fft_ready = 1;
        @(negedge CLK);
        fft_ready = 0;
        check("bp_frames", {120'd0, frames_done}, 128'd2);
        check("bp_sready_back", {127'd0, s_ready}, 128'd1);

        // flush after 3 samples
        exp_re = '0; exp_im = '0;
        for (int k = 0; k < 3; k++) begin
            push(16'((k + 1) * 256), 16'((k + 1) * 17), 0);
            exp_re[k*16 +: 16] = 16'((k + 1) * 256);
            exp_im[k*16 +: 16] = 16'((k + 1) * 17);
        end
        @(negedge CLK);
        s_valid = 0; flush = 1;
        @(negedge CLK);
        flush = 0;
        check("fl_pad_write", {127'd0, fft_write}, 128'd0);
        check("fl_pad_sready", {127'd0, s_ready}, 128'd0);
        @(negedge CLK);
        check("fl_load_write", {127'd0, fft_write}, 128'd1);
        check("fl_real", frame_real, exp_re);
        check("fl_imag", frame_imag, exp_im);
        @(negedge CLK);
        check("fl_write_once", {127'd0, fft_write}, 128'd0);
        check("fl_start", {127'd0, fft_start}, 128'd1);
        fft_ready = 1;
        @(negedge CLK);
        fft_ready = 0;
        check("fl_frames", {120'd0, frames_done}, 128'd3);

        // flush at idx 0 is ignored
        flush = 1;
        @(negedge CLK);
        flush = 0;
        check("fl0_sready", {127'd0, s_ready}, 128'd1);
        check("fl0_write", {127'd0, fft_write}, 128'd0);
        @(negedge CLK);
        check("fl0_sready2", {127'd0, s_ready}, 128'd1);
        check("fl0_write2", {127'd0, fft_write}, 128'd0);

        // flush together with the 8th accept
        for (int k = 0; k < 8; k++) begin
            push(16'h0A00 + 16'(k), 16'h0B00 + 16'(k), k == 7);
            exp_re[k*16 +: 16] = 16'h0A00 + 16'(k);
            exp_im[k*16 +: 16] = 16'h0B00 + 16'(k);
        end
        idle;
        check("f8_write", {127'd0, fft_write}, 128'd1);
        check("f8_real", frame_real, exp_re);
        check("f8_imag", frame_imag, exp_im);
        @(negedge CLK);
        check("f8_write_once", {127'd0, fft_write}, 128'd0);
        check("f8_start", {127'd0, fft_start}, 128'd1);
        fft_ready = 1;
        @(negedge CLK);
        check("f8_frames", {120'd0, frames_done}, 128'd4);

        // stale ready: fft_ready stays high into the next frame
        for (int k = 0; k < 8; k++) push(16'h0C00 + 16'(k), 16'h0000, 0);
        idle;
        repeat (10) @(negedge CLK);
        check("stale_start", {127'd0, fft_start}, 128'd1);
        check("stale_frames", {120'd0, frames_done}, 128'd4);
        fft_ready = 0;
        repeat (2) @(negedge CLK);
        check("stale_busy", {127'd0, busy}, 128'd1);
        fft_ready = 1;
        @(negedge CLK);
        check("stale_done", {120'd0, frames_done}, 128'd5);
        check("stale_sready", {127'd0, s_ready}, 128'd1);
        repeat (3) @(negedge CLK);
        check("stale_once", {120'd0, frames_done}, 128'd5);

        // async reset mid-RUN
        for (int k = 0; k < 8; k++) push(16'h0D00 + 16'(k), 16'h0E00, 0);
        idle;
        @(negedge CLK);
        check("ar_in_run", {127'd0, fft_start}, 128'd1);
        @(posedge CLK);
        #2 RST_N = 0;
        #1;
        check("ar_start", {127'd0, fft_start}, 128'd0);
        check("ar_busy", {127'd0, busy}, 128'd0);
        check("ar_write", {127'd0, fft_write}, 128'd0);
        check("ar_sready", {127'd0, s_ready}, 128'd1);
        check("ar_frames", {120'd0, frames_done}, 128'd0);
        check("ar_frame", frame_real | frame_imag, 128'd0);
        @(negedge CLK);
        RST_N = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
